// File: rtl/mdio_link_poller.sv
// Background BMSR link poller with priority arbitration for software MDIO
// register accesses; drives the transceiver request strobes.
module mdio_link_poller #(
  parameter int unsigned POLL_INTERVAL = 25000000,
  parameter logic [4:0]  BMSR_ADDR     = 5'd1,
  parameter int unsigned LINK_BIT      = 2,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        poll_en,
  input  logic [4:0]  sw_reg_addr,
  input  logic [15:0] sw_wr_data,
  input  logic        sw_reg_wr,
  input  logic        sw_reg_rd,
  output logic [15:0] sw_rd_data,
  output logic        sw_busy,
  output logic [4:0]  phy_reg_addr,
  output logic [15:0] phy_wr_data,
  output logic        phy_reg_wr,
  output logic        phy_reg_rd,
  input  logic [15:0] phy_rd_data,
  input  logic        mdio_busy,
  output logic        link_up,
  output logic        link_change,
  output logic [15:0] bmsr,
  output logic        timeout_err
);

  localparam int TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(POLL_INTERVAL - 1);
  localparam logic [CW-1:0] C_LAST = CW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] timer;
  logic [CW-1:0] to_cnt;
  logic          poll_pending;
  logic          sw_pending;
  logic          owner_sw;
  logic          op_wr;
  logic [4:0]    sw_addr;
  logic [15:0]   sw_data;
  logic          sw_wr;
  logic          sw_req;
  logic          poll_tc;
  logic          done;
  logic          timeout;
  logic          grant_sw;
  logic          grant_poll;

  assign sw_busy     = sw_pending;
  assign sw_req      = (sw_reg_rd | sw_reg_wr) & ~sw_pending;
  assign poll_tc     = poll_en && (timer == T_LAST);
  assign phy_reg_rd  = (state == ISSUE) && !op_wr;
  assign phy_reg_wr  = (state == ISSUE) && op_wr;
  assign timeout_err = timeout;

  always_comb begin
    state_nxt  = state;
    done       = 1'b0;
    timeout    = 1'b0;
    grant_sw   = 1'b0;
    grant_poll = 1'b0;
    unique case (state)
      IDLE: begin
        if (sw_pending) begin
          grant_sw  = 1'b1;
          state_nxt = ISSUE;
        end else if (poll_pending) begin
          grant_poll = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (mdio_busy) begin
          state_nxt = WAIT_DONE;
        end else if (to_cnt == C_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!mdio_busy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A fresh terminal count wins over clearing, so a poll never gets lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer        <= '0;
      poll_pending <= 1'b0;
    end else if (!poll_en) begin
      timer        <= '0;
      poll_pending <= 1'b0;
    end else begin
      timer <= poll_tc ? '0 : timer + 1'b1;
      if (poll_tc)
        poll_pending <= 1'b1;
      else if ((done || timeout) && !owner_sw)
        poll_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_pending <= 1'b0;
      sw_addr    <= '0;
      sw_data    <= '0;
      sw_wr      <= 1'b0;
      sw_rd_data <= '0;
    end else begin
      if (sw_req) begin
        sw_pending <= 1'b1;
        sw_addr    <= sw_reg_addr;
        sw_data    <= sw_wr_data;
        sw_wr      <= sw_reg_wr;
      end else if ((done || timeout) && owner_sw) begin
        sw_pending <= 1'b0;
      end
      if (done && owner_sw && !op_wr)
        sw_rd_data <= phy_rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_sw     <= 1'b0;
      op_wr        <= 1'b0;
      phy_reg_addr <= '0;
      phy_wr_data  <= '0;
      to_cnt       <= '0;
    end else begin
      if (grant_sw) begin
        owner_sw     <= 1'b1;
        op_wr        <= sw_wr;
        phy_reg_addr <= sw_addr;
        phy_wr_data  <= sw_data;
      end else if (grant_poll) begin
        owner_sw     <= 1'b0;
        op_wr        <= 1'b0;
        phy_reg_addr <= BMSR_ADDR;
      end
      if (state == ISSUE)
        to_cnt <= '0;
      else if (state == WAIT_BUSY)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bmsr        <= '0;
      link_up     <= 1'b0;
      link_change <= 1'b0;
    end else begin
      link_change <= 1'b0;
      if (done && !owner_sw) begin
        bmsr        <= phy_rd_data;
        link_up     <= phy_rd_data[LINK_BIT];
        link_change <= phy_rd_data[LINK_BIT] ^ link_up;
      end
    end
  end

endmodule

// File: tb/tb_mdio_link_poller.sv
// Scoreboard bench: transceiver model, strobe/result monitor, directed
// corner cases and randomized software traffic under background polling.
module tb_mdio_link_poller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        poll_en = 1'b0;
  logic [4:0]  sw_reg_addr = '0;
  logic [15:0] sw_wr_data = '0;
  logic        sw_reg_wr = 1'b0;
  logic        sw_reg_rd = 1'b0;
  logic [15:0] phy_rd_data = '0;
  logic        mdio_busy = 1'b0;
  logic [15:0] sw_rd_data;
  logic        sw_busy;
  logic [4:0]  phy_reg_addr;
  logic [15:0] phy_wr_data;
  logic        phy_reg_wr;
  logic        phy_reg_rd;
  logic        link_up;
  logic        link_change;
  logic [15:0] bmsr;
  logic        timeout_err;

  mdio_link_poller #(.POLL_INTERVAL(100)) dut (
    .clk(clk), .rst(rst), .poll_en(poll_en),
    .sw_reg_addr(sw_reg_addr), .sw_wr_data(sw_wr_data),
    .sw_reg_wr(sw_reg_wr), .sw_reg_rd(sw_reg_rd),
    .sw_rd_data(sw_rd_data), .sw_busy(sw_busy),
    .phy_reg_addr(phy_reg_addr), .phy_wr_data(phy_wr_data),
    .phy_reg_wr(phy_reg_wr), .phy_reg_rd(phy_reg_rd),
    .phy_rd_data(phy_rd_data), .mdio_busy(mdio_busy),
    .link_up(link_up), .link_change(link_change),
    .bmsr(bmsr), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] data;
  } op_t;

  int checks = 0;
  int failures = 0;
  op_t sw_exp[$];
  logic [15:0] poll_exp[$];
  logic [15:0] poll_force[$];
  logic [15:0] sw_force[$];
  int slog[$];
  int scyc[$];
  int cyc = 0;
  logic ref_link = 1'b0;
  logic [15:0] ref_rd = '0;
  bit no_busy = 0;
  bit abort = 0;
  bit mdl_active = 0;
  bit mdl_poll = 0;
  int polls_done = 0;
  int sw_strobes = 0;
  int lc_pulses = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  always @(posedge clk) cyc++;

  // Transceiver: busy one cycle after a strobe, for 40 cycles.
  initial begin
    logic [15:0] resp;
    bit is_poll;
    bit rd;
    forever begin
      @(negedge clk);
      if (!rst && (phy_reg_rd || phy_reg_wr)) begin
        is_poll = phy_reg_rd && (phy_reg_addr == 5'd1);
        rd = phy_reg_rd;
        mdl_poll = is_poll;
        mdl_active = 1;
        if (no_busy) begin
          repeat (63) @(negedge clk);
          chk("timeout_early", 32'(timeout_err), 32'd0);
          @(negedge clk);
          chk("timeout_at_64", 32'(timeout_err), 32'd1);
        end else begin
          @(negedge clk);
          mdio_busy = 1'b1;
          repeat (40) @(negedge clk);
          if (is_poll)
            resp = poll_force.size() > 0 ? poll_force.pop_front() : 16'($urandom);
          else if (rd)
            resp = sw_force.size() > 0 ? sw_force.pop_front() : 16'($urandom);
          else
            resp = 16'($urandom);
          phy_rd_data = resp;
          mdio_busy = 1'b0;
          if (is_poll) begin
            if (abort) abort = 0;
            else poll_exp.push_back(resp);
          end else if (rd) begin
            ref_rd = resp;
          end
        end
        mdl_active = 0;
      end
    end
  end

  // Monitor: strobes, poll results, software completions, stray pulses.
  initial begin
    op_t e;
    logic [15:0] v;
    bit pb;
    pb = 0;
    forever begin
      @(posedge clk);
      #2;
      if (phy_reg_rd || phy_reg_wr) begin
        scyc.push_back(cyc);
        if (phy_reg_rd && phy_reg_addr == 5'd1) begin
          slog.push_back(1);
        end else begin
          slog.push_back(0);
          sw_strobes++;
          if (sw_exp.size() == 0) begin
            fail("unexpected_sw_strobe");
          end else begin
            e = sw_exp.pop_front();
            chk("strobe_dir", 32'(phy_reg_wr), 32'(e.wr));
            chk("strobe_addr", 32'(phy_reg_addr), 32'(e.addr));
            if (e.wr) chk("strobe_wdata", 32'(phy_wr_data), 32'(e.data));
          end
        end
      end
      if (poll_exp.size() > 0) begin
        v = poll_exp.pop_front();
        chk("poll_bmsr", 32'(bmsr), 32'(v));
        chk("poll_link_up", 32'(link_up), 32'(v[2]));
        chk("poll_link_change", 32'(link_change), 32'(v[2] ^ ref_link));
        ref_link = v[2];
        polls_done++;
      end else if (link_change) begin
        fail("unexpected_link_change");
      end
      if (link_change) lc_pulses++;
      if (timeout_err && !no_busy) fail("unexpected_timeout");
      if (pb && !sw_busy) chk("sw_rd_data", 32'(sw_rd_data), 32'(ref_rd));
      pb = sw_busy;
    end
  end

  task automatic sw_op(bit rd, bit wr, logic [4:0] a, logic [15:0] d);
    sw_reg_rd = rd;
    sw_reg_wr = wr;
    sw_reg_addr = a;
    sw_wr_data = d;
    if (!sw_busy && (rd || wr)) sw_exp.push_back(op_t'{wr, a, d});
    @(negedge clk);
    sw_reg_rd = 1'b0;
    sw_reg_wr = 1'b0;
  endtask

  task automatic wait_quiet(int maxc);
    int n = 0;
    while ((sw_busy || mdl_active || sw_exp.size() > 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) fail("wait_quiet_bound");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_polls(int target, int maxc);
    int n = 0;
    while (polls_done < target && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) fail("wait_polls_bound");
  endtask

  initial begin
    int base;
    int n0;
    int p0;
    int n;
    int k;
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n0;
    int p0;
    int n;
    int k;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 32'({sw_rd_data, sw_busy, phy_reg_addr, phy_reg_wr,
                          phy_reg_rd, link_up, link_change, timeout_err}), 32'd0);
    chk("reset_bmsr", 32'(bmsr), 32'd0);
    chk("reset_wdata", 32'(phy_wr_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Latency and dropped second request.
    base = sw_strobes;
    sw_force.push_back(16'h0141);
    sw_op(1, 0, 5'd2, 16'h0);
    chk("sw_busy_at_1", 32'(sw_busy), 32'd1);
    sw_op(1, 0, 5'd3, 16'h0);
    chk("strobe_at_2", 32'(phy_reg_rd), 32'd1);
    chk("strobe_at_2_addr", 32'(phy_reg_addr), 32'd2);
    wait_quiet(200);
    chk("single_sw_strobe", 32'(sw_strobes - base), 32'd1);
    chk("sw_rd_0141", 32'(sw_rd_data), 32'h0141);
    chk("bmsr_untouched", 32'({bmsr, link_up}), 32'd0);

    // Two polls: link stays down, then comes up.
    poll_force.push_back(16'h7949);
    poll_force.push_back(16'h796D);
    p0 = polls_done;
    poll_en = 1'b1;
    wait_polls(p0 + 2, 400);
    poll_en = 1'b0;
    chk("lc_pulses", 32'(lc_pulses), 32'd1);
    chk("link_up_after_796d", 32'(link_up), 32'd1);
    wait_quiet(200);

    // Software write coinciding with poll terminal count.
    poll_force.push_back(16'h796D);
    p0 = polls_done;
    n0 = slog.size();
    poll_en = 1'b1;
    repeat (99) @(negedge clk);
    sw_op(0, 1, 5'd0, 16'h8000);
    n = 0;
    while (slog.size() < n0 + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (slog.size() < n0 + 2) begin
      fail("arb_strobes_missing");
    end else begin
      chk("arb_first_sw", 32'(slog[n0]), 32'd0);
      chk("arb_then_poll", 32'(slog[n0+1]), 32'd1);
      chk("arb_gap", 32'(scyc[n0+1] - scyc[n0]), 32'd43);
    end
    wait_polls(p0 + 1, 300);
    poll_en = 1'b0;
    wait_quiet(200);

    // Start timeout, then a normal access is accepted.
    no_busy = 1;
    sw_op(1, 0, 5'd5, 16'h0);
    wait_quiet(300);
    no_busy = 0;
    chk("timeout_busy_clear", 32'(sw_busy), 32'd0);
    chk("timeout_rd_kept", 32'(sw_rd_data), 32'h0141);
    sw_op(1, 0, 5'd7, 16'h0);
    wait_quiet(200);

    // Reset in WAIT_DONE of a poll.
    poll_en = 1'b1;
    n = 0;
    while (!(mdio_busy && mdl_poll) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) fail("reset_poll_bound");
    repeat (5) @(negedge clk);
    chk("link_before_rst", 32'(link_up), 32'd1);
    #2;
    abort = 1;
    rst = 1'b1;
    #1;
    chk("rst_async_ctl", 32'({sw_rd_data, sw_busy, link_up, link_change,
                              timeout_err, phy_reg_rd, phy_reg_wr}), 32'd0);
    chk("rst_async_bmsr", 32'(bmsr), 32'd0);
    ref_link = 1'b0;
    ref_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("link_held_low", 32'(link_up), 32'd0);
    p0 = polls_done;
    wait_polls(p0 + 1, 300);

    // Random software traffic against background polls.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 70)) @(negedge clk);
      k = $urandom_range(0, 2);
      sw_op(k != 1, k != 0, 5'($urandom_range(2, 31)), 16'($urandom));
    end
    poll_en = 1'b0;
    wait_quiet(600);
    chk("sw_exp_drained", 32'(sw_exp.size()), 32'd0);
    chk("poll_exp_drained", 32'(poll_exp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
